// File: rtl/instr_mem_server.sv
// Instruction-memory responder: streams a program image in over a byte-wide
// load port, then serves 32-bit words combinationally from the core's PC.
module instr_mem_server #(
  parameter int unsigned DEPTH_W = 8
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic [10:0] PC,
  output logic [31:0] instr,
  input  logic        load_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        loaded,
  output logic        load_err
);

  localparam int unsigned DEPTH = 2 ** DEPTH_W;
  localparam int unsigned CNT_W = DEPTH_W + 1;

  typedef enum logic [2:0] {
    S_EMPTY,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_SERVE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DEPTH_W-1:0] waddr_q, waddr_d;
  logic [1:0]         lane_q, lane_d;
  logic [23:0]        word_q, word_d;
  logic [7:0]         hdr_lo_q, hdr_lo_d;
  logic               load_err_q, load_err_d;

  logic [31:0]        mem_q [DEPTH];
  logic               mem_we;
  logic [31:0]        mem_wdata;

  logic               xfer;
  logic [15:0]        hdr_count;
  logic [DEPTH_W-1:0] idx;
  logic               pc_in_range;
  logic               unused_pc_lsb;

  assign byte_ready = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_DATA);
  assign loaded     = (state_q == S_SERVE);
  assign load_err   = load_err_q;
  assign xfer       = byte_valid && byte_ready;
  assign hdr_count  = {byte_data, hdr_lo_q};

  // Next-state and load datapath.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    waddr_d    = waddr_q;
    lane_d     = lane_q;
    word_d     = word_q;
    hdr_lo_d   = hdr_lo_q;
    load_err_d = load_err_q;
    mem_we     = 1'b0;
    mem_wdata  = {byte_data, word_q};

    case (state_q)
      S_EMPTY, S_SERVE: begin
        if (load_start) begin
          state_d    = S_HDR0;
          count_d    = '0;
          load_err_d = 1'b0;
          waddr_d    = '0;
          lane_d     = '0;
        end
      end
      S_HDR0: begin
        if (xfer) begin
          hdr_lo_d = byte_data;
          state_d  = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          waddr_d = '0;
          lane_d  = '0;
          if (hdr_count == 16'd0) begin
            count_d = '0;
            state_d = S_EMPTY;
          end else if (32'(hdr_count) > DEPTH) begin
            // Oversized image: keep the first DEPTH words and flag it.
            count_d    = CNT_W'(DEPTH);
            load_err_d = 1'b1;
            state_d    = S_DATA;
          end else begin
            count_d = CNT_W'(hdr_count);
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0:    word_d[7:0]   = byte_data;
            2'd1:    word_d[15:8]  = byte_data;
            2'd2:    word_d[23:16] = byte_data;
            default: begin
              mem_we  = 1'b1;
              waddr_d = waddr_q + DEPTH_W'(1);
              if (CNT_W'(waddr_q) + CNT_W'(1) == count_q) begin
                state_d = S_SERVE;
              end
            end
          endcase
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Control and load registers.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      count_q    <= '0;
      waddr_q    <= '0;
      lane_q     <= '0;
      word_q     <= '0;
      hdr_lo_q   <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      waddr_q    <= waddr_d;
      lane_q     <= lane_d;
      word_q     <= word_d;
      hdr_lo_q   <= hdr_lo_d;
      load_err_q <= load_err_d;
    end
  end

  // Image storage; contents survive reset, the zeroed count hides stale words.
  always_ff @(posedge CLOCK_50) begin
    if (mem_we && !rst) begin
      mem_q[waddr_q] <= mem_wdata;
    end
  end

  assign idx           = PC[DEPTH_W+1:2];
  assign pc_in_range   = (PC >> (DEPTH_W + 2)) == 11'd0;
  assign unused_pc_lsb = ^PC[1:0];

  // Zero-latency fetch for the single-cycle core.
  always_comb begin
    instr = '0;
    if (loaded && pc_in_range && (CNT_W'(idx) < count_q)) begin
      instr = mem_q[idx];
    end
  end

endmodule

// File: tb/tb_instr_mem_server.sv
// Directed bench for instr_mem_server: image loads with bubbles, clamping,
// empty headers, reload from SERVE and reset during a load.
module tb_instr_mem_server;

  logic        CLOCK_50 = 1'b0;
  logic        rst;
  logic [10:0] PC;
  logic [31:0] instr;
  logic        load_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        loaded;
  logic        load_err;

  int vectors = 0;
  int errors  = 0;

  instr_mem_server #(.DEPTH_W(8)) dut (
    .CLOCK_50   (CLOCK_50),
    .rst        (rst),
    .PC         (PC),
    .instr      (instr),
    .load_start (load_start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .loaded     (loaded),
    .load_err   (load_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_pc(input logic [10:0] pc, input logic [31:0] exp, input string tag);
    PC = pc;
    #2;
    check(tag, instr, exp);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    #2;
  endtask

  // Offer one byte after some idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int bubbles);
    int guard;
    for (int i = 0; i < bubbles; i++) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    #2;
    guard = 0;
    while (!byte_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("byte_ready_wait", 32'(byte_ready), 32'h1);
    tick();
    byte_valid = 1'b0;
    #2;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_bubble);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(0, max_bubble));
  endtask

  initial begin
    logic [31:0] w;
    rst        = 1'b1;
    PC         = '0;
    load_start = 1'b0;
    byte_valid = 1'b0;
    byte_data  = '0;
    tick();
    tick();
    rst = 1'b0;
    #2;
    check("rst_instr", instr, 32'h0);
    check("rst_ready", 32'(byte_ready), 32'h0);
    check("rst_loaded", 32'(loaded), 32'h0);
    check("rst_err", 32'(load_err), 32'h0);

    // Two-word image with random bubbles
    pulse_start();
    check("start_ready", 32'(byte_ready), 32'h1);
    send_byte(8'h02, $urandom_range(0, 2));
    send_byte(8'h00, $urandom_range(0, 2));
    send_word(32'h00500093, 2);
    send_byte(8'h33, $urandom_range(0, 2));
    send_byte(8'h81, $urandom_range(0, 2));
    send_byte(8'h10, $urandom_range(0, 2));
    byte_valid = 1'b1;
    byte_data  = 8'h00;
    #2;
    check("last_byte_ready", 32'(byte_ready), 32'h1);
    check("pre_last_loaded", 32'(loaded), 32'h0);
    tick();
    byte_valid = 1'b0;
    #2;
    check("post_last_loaded", 32'(loaded), 32'h1);
    check("serve_ready", 32'(byte_ready), 32'h0);
    check_pc(11'h000, 32'h00500093, "c2_pc0");
    check_pc(11'h004, 32'h00108133, "c2_pc4");
    check_pc(11'h008, 32'h00000000, "c2_pc8");
    check_pc(11'h005, 32'h00108133, "c2_pc5");
    check_pc(11'h400, 32'h00000000, "c2_pc400");

    // Oversized header: 300 words clamps to 256
    PC = 11'h000;
    pulse_start();
    check("reload_instr", instr, 32'h0);
    check("reload_loaded", 32'(loaded), 32'h0);
    send_byte(8'h2C, 0);
    send_byte(8'h01, 0);
    check("clamp_err", 32'(load_err), 32'h1);
    for (int i = 0; i < 256; i++) begin
      w = 32'hCAFE0000 | 32'(i);
      send_word(w, 0);
    end
    check("clamp_ready_low", 32'(byte_ready), 32'h0);
    check("clamp_loaded", 32'(loaded), 32'h1);
    check("clamp_err_sticky", 32'(load_err), 32'h1);
    check_pc(11'h000, 32'hCAFE0000, "clamp_pc0");
    check_pc(11'h200, 32'hCAFE0080, "clamp_pc200");
    check_pc(11'h3FC, 32'hCAFE00FF, "clamp_pc3fc");
    check_pc(11'h400, 32'h00000000, "clamp_pc400");
    check_pc(11'h7FC, 32'h00000000, "clamp_pc7fc");

    // Zero-length header returns to EMPTY
    pulse_start();
    check("err_cleared", 32'(load_err), 32'h0);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    check("c0_loaded", 32'(loaded), 32'h0);
    check("c0_ready", 32'(byte_ready), 32'h0);
    check_pc(11'h000, 32'h0, "c0_pc0");
    check_pc(11'h004, 32'h0, "c0_pc4");
    check_pc(11'h3FC, 32'h0, "c0_pc3fc");

    // One-word image; load_start inside DATA must be ignored
    pulse_start();
    send_byte(8'h01, 1);
    send_byte(8'h00, 1);
    send_byte(8'hEF, 1);
    send_byte(8'hBE, 1);
    pulse_start();
    check("data_start_ignored", 32'(byte_ready), 32'h1);
    send_byte(8'hAD, 1);
    send_byte(8'hDE, 1);
    check("c1_loaded", 32'(loaded), 32'h1);
    check_pc(11'h000, 32'hDEADBEEF, "c1_pc0");
    check_pc(11'h004, 32'h00000000, "c1_pc4");

    // load_start with a simultaneous byte in SERVE: no transfer
    PC         = 11'h000;
    load_start = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h07;
    #2;
    check("serve_no_ready", 32'(byte_ready), 32'h0);
    tick();
    load_start = 1'b0;
    byte_valid = 1'b0;
    #2;
    check("restart_instr", instr, 32'h0);
    check("restart_ready", 32'(byte_ready), 32'h1);
    check("restart_loaded", 32'(loaded), 32'h0);

    // Reset after five data bytes, then a clean reload
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    pulse_start();
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    check("midrst_ready", 32'(byte_ready), 32'h0);
    check("midrst_loaded", 32'(loaded), 32'h0);
    check("midrst_instr", instr, 32'h0);
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'h00000013, 1);
    check("final_loaded", 32'(loaded), 32'h1);
    check("final_err", 32'(load_err), 32'h0);
    check_pc(11'h000, 32'h00000013, "final_pc0");
    check_pc(11'h004, 32'h00000000, "final_pc4");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
